// File: rtl/store_pkg.sv
// ============================================================================
// Module  : store_pkg
// Brief   : Shared store encodings, FSM states and big-endian lane constants.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } st_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DONE  = 2'b10,
    ST_FAULT = 2'b11
  } state_e;

  // Big-endian: byte offset 0 lives in bits 31:24, i.e. be[3].
  localparam logic [3:0] c_BE_BYTE_OFF0 = 4'b1000;
  localparam logic [3:0] c_BE_HALF_OFF0 = 4'b1100;
  localparam logic [3:0] c_BE_HALF_OFF2 = 4'b0011;
  localparam logic [3:0] c_BE_WORD      = 4'b1111;

  function automatic logic is_misaligned(input st_size_e size, input logic [1:0] offset);
    logic r;
    r = 1'b0;
    case (size)
      SZ_HALF: r = offset[0];
      SZ_WORD: r = |offset;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_lane_mux.sv
// ============================================================================
// Module  : store_lane_mux
// Brief   : Narrows store data, replicates it across lanes and builds byte
//           enables. STORE_MISALIGN_TRAP_EN makes misaligned stores reject.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module store_lane_mux
  import store_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_data,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic        o_reject
);

  st_size_e w_size;

  assign w_size = st_size_e'(i_size);

  // Enables ignore the sub-alignment bits, so misaligned requests fall
  // naturally onto their aligned lanes when they are not trapped.
  always_comb begin
    o_wdata = i_data;
    o_be    = c_BE_WORD;
    case (w_size)
      SZ_BYTE: begin
        o_wdata = {4{i_data[7:0]}};
        o_be    = c_BE_BYTE_OFF0 >> i_offset;
      end
      SZ_HALF: begin
        o_wdata = {2{i_data[15:0]}};
        o_be    = i_offset[1] ? c_BE_HALF_OFF2 : c_BE_HALF_OFF0;
      end
      default: begin
        o_wdata = i_data;
        o_be    = c_BE_WORD;
      end
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  assign o_reject = (w_size == SZ_RSVD) | is_misaligned(w_size, i_offset);
`else
  assign o_reject = (w_size == SZ_RSVD);
`endif

endmodule

`default_nettype wire

// File: rtl/store_narrow_unit.sv
// ============================================================================
// Module  : store_narrow_unit
// Brief   : Store FSM issuing one narrowed, lane-replicated memory write with
//           ack timeout. Optional misalign trap: STORE_MISALIGN_TRAP_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module store_narrow_unit
  import store_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              st_ready,
  output logic              st_done,
  output logic              st_fault,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e            r_state;
  state_e            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_be;
  logic [31:0]       w_wdata;
  logic [3:0]        w_be;
  logic              w_reject;
  logic              w_accept;

  store_lane_mux u_lane_mux (
    .i_size   (st_size),
    .i_offset (st_addr[1:0]),
    .i_data   (st_data),
    .o_wdata  (w_wdata),
    .o_be     (w_be),
    .o_reject (w_reject)
  );

  assign w_accept = st_valid & (r_state == ST_IDLE) & ~w_reject;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Ack is checked before expiry so a last-cycle ack still completes.
  always_comb begin
    w_state_next = r_state;
    st_ready     = 1'b0;
    st_done      = 1'b0;
    st_fault     = 1'b0;
    mem_req      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        st_ready = 1'b1;
        if (st_valid) begin
          w_state_next = w_reject ? ST_FAULT : ST_BUSY;
        end
      end
      ST_BUSY: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_state_next = ST_DONE;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_next = ST_FAULT;
        end
      end
      ST_DONE: begin
        st_done      = 1'b1;
        w_state_next = ST_IDLE;
      end
      ST_FAULT: begin
        st_fault     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Counts cycles already spent in BUSY; zero on the first mem_req cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_BUSY) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else if (w_accept) begin
      r_mem_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
      r_mem_wdata <= w_wdata;
      r_mem_be    <= w_be;
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

endmodule

`default_nettype wire

// File: tb/tb_store_narrow_unit.sv
// ============================================================================
// Module  : tb_store_narrow_unit
// Brief   : Directed self-checking bench for store_narrow_unit (TIMEOUT_CYC=4).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_store_narrow_unit;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              st_valid = 1'b0;
  logic [1:0]        st_size = 2'b00;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [31:0]       st_data = '0;
  logic              st_ready;
  logic              st_done;
  logic              st_fault;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  store_narrow_unit #(
    .TIMEOUT_CYC (4),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_size   (st_size),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .st_done   (st_done),
    .st_fault  (st_fault),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic check_mem(input string tag, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd);
    check({tag, "_req"},   64'(mem_req),   64'd1);
    check({tag, "_addr"},  64'(mem_addr),  64'(a));
    check({tag, "_be"},    64'(mem_be),    64'(be));
    check({tag, "_wdata"}, 64'(mem_wdata), 64'(wd));
  endtask

  task automatic check_done_then_idle(input string tag);
    check({tag, "_done"},     64'(st_done),  64'd1);
    check({tag, "_req_drop"}, 64'(mem_req),  64'd0);
    check({tag, "_nofault"},  64'(st_fault), 64'd0);
    tick();
    check({tag, "_done_clr"}, 64'(st_done),  64'd0);
    check({tag, "_ready"},    64'(st_ready), 64'd1);
  endtask

  initial begin
    // Reset values while rst_n is held low
    #2;
    check("rst_ready", 64'(st_ready),  64'd1);
    check("rst_req",   64'(mem_req),   64'd0);
    check("rst_done",  64'(st_done),   64'd0);
    check("rst_fault", 64'(st_fault),  64'd0);
    check("rst_be",    64'(mem_be),    64'd0);
    check("rst_addr",  64'(mem_addr),  64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Byte at offset 3, ack on the second mem_req cycle; st_valid in BUSY ignored
    issue(2'b00, 32'h0000_1003, 32'h0000_00AB);
    check_mem("b3", 32'h0000_1000, 4'b0001, 32'hABAB_ABAB);
    check("b3_busy_ready", 64'(st_ready), 64'd0);
    st_valid = 1'b1;
    st_size  = 2'b11;
    tick();
    check_mem("b3_hold", 32'h0000_1000, 4'b0001, 32'hABAB_ABAB);
    mem_ack = 1'b1;
    tick();
    mem_ack  = 1'b0;
    st_valid = 1'b0;
    check_done_then_idle("b3");

    // Byte at offset 0, ack on the first mem_req cycle (minimum latency)
    issue(2'b00, 32'h0000_1000, 32'hFFFF_FF5A);
    check_mem("b0", 32'h0000_1000, 4'b1000, 32'h5A5A_5A5A);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_done_then_idle("b0");

    // Half at offset 2
    issue(2'b01, 32'h0000_2002, 32'h1234_CDEF);
    check_mem("h2", 32'h0000_2000, 4'b0011, 32'hCDEF_CDEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_done_then_idle("h2");

    // Misaligned half and word
`ifdef STORE_MISALIGN_TRAP_EN
    issue(2'b01, 32'h0000_2001, 32'h0000_BEEF);
    check("h1_fault", 64'(st_fault), 64'd1);
    check("h1_noreq", 64'(mem_req),  64'd0);
    tick();
    check("h1_fault_clr", 64'(st_fault), 64'd0);
    issue(2'b10, 32'h0000_3001, 32'hDEAD_BEEF);
    check("w1_fault", 64'(st_fault), 64'd1);
    check("w1_noreq", 64'(mem_req),  64'd0);
    tick();
    check("w1_fault_clr", 64'(st_fault), 64'd0);
    check("w1_noreq2",    64'(mem_req),  64'd0);
`else
    issue(2'b01, 32'h0000_2001, 32'h0000_BEEF);
    check_mem("h1", 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_done_then_idle("h1");
    issue(2'b10, 32'h0000_3001, 32'hDEAD_BEEF);
    check_mem("w1", 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_done_then_idle("w1");
`endif

    // Timeout: no ack, mem_req high for exactly 4 cycles then fault
    issue(2'b10, 32'h0000_4000, 32'h0102_0304);
    for (int i = 0; i < 4; i++) begin
      check_mem($sformatf("to_c%0d", i), 32'h0000_4000, 4'b1111, 32'h0102_0304);
      tick();
    end
    check("to_req_drop", 64'(mem_req),  64'd0);
    check("to_fault",    64'(st_fault), 64'd1);
    check("to_nodone",   64'(st_done),  64'd0);
    tick();
    check("to_fault_clr", 64'(st_fault), 64'd0);
    check("to_ready",     64'(st_ready), 64'd1);

    // Ack coinciding with the expiry cycle wins
    issue(2'b10, 32'h0000_4004, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ta_req_c%0d", i), 64'(mem_req), 64'd1);
      tick();
    end
    check("ta_req_c3", 64'(mem_req), 64'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_done_then_idle("ta");

    // Reserved size rejects without a memory request
    issue(2'b11, 32'h0000_5000, 32'h5555_5555);
    check("rsv_fault", 64'(st_fault), 64'd1);
    check("rsv_noreq", 64'(mem_req),  64'd0);
    tick();
    check("rsv_fault_clr", 64'(st_fault), 64'd0);
    check("rsv_noreq2",    64'(mem_req),  64'd0);

    // Ack while idle is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_ready", 64'(st_ready), 64'd1);
    check("idle_ack_done",  64'(st_done),  64'd0);

    // Asynchronous reset in the middle of BUSY
    issue(2'b10, 32'h0000_6000, 32'h1122_3344);
    check("ar_req_pre", 64'(mem_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_req",   64'(mem_req),  64'd0);
    check("ar_be",    64'(mem_be),   64'd0);
    check("ar_addr",  64'(mem_addr), 64'd0);
    check("ar_ready", 64'(st_ready), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ar_post_ready%0d", i), 64'(st_ready), 64'd1);
      check($sformatf("ar_post_done%0d", i),  64'(st_done),  64'd0);
      check($sformatf("ar_post_fault%0d", i), 64'(st_fault), 64'd0);
      check($sformatf("ar_post_req%0d", i),   64'(mem_req),  64'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_narrow_unit.md
STORE_NARROW_UNIT -- requirements
Module: store_narrow_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, giving the maximum cycles to wait for mem_ack before aborting.
REQ-002 SHALL have parameter ADDR_W, default 32, giving the address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port st_valid, input, 1, store request from the MEM stage.
REQ-006 SHALL have port st_size, input, 2, store size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-007 SHALL have port st_addr, input, ADDR_W, byte address.
REQ-008 SHALL have port st_data, input, 32, register rt value; narrowing takes its low bits.
REQ-009 SHALL have port st_ready, output, 1, high when a request can be accepted.
REQ-010 SHALL have port st_done, output, 1, one-cycle pulse on store completion.
REQ-011 SHALL have port st_fault, output, 1, one-cycle pulse on a rejected or aborted store.
REQ-012 SHALL have port mem_req, output, 1, write request held high until acknowledged.
REQ-013 SHALL have port mem_addr, output, ADDR_W, word-aligned address with bits [1:0] = 00.
REQ-014 SHALL have port mem_wdata, output, 32, narrowed data replicated across all lanes.
REQ-015 SHALL have port mem_be, output, 4, byte enables (be[3] = bits 31:24).
REQ-016 SHALL have port mem_ack, input, 1, memory accepted the write.

Function
REQ-017 SHALL use a big-endian lane map: byte offset 0 = bits 31:24, offset 3 = bits 7:0.
REQ-018 SHALL produce byte stores as data = {4{st_data[7:0]}} and be = 1000 >> addr[1:0].
REQ-019 SHALL produce half stores as data = {2{st_data[15:0]}} and be = 1100 (addr[1] = 0) or 0011 (addr[1] = 1).
REQ-020 SHALL produce word stores as data = st_data and be = 1111.
REQ-021 SHALL implement the FSM states IDLE, BUSY, DONE and FAULT.
REQ-022 SHALL make the transition IDLE -> BUSY on st_valid & st_ready with a legal request, registering addr, data and be; mem_req rises the following cycle.
REQ-023 SHALL make the transition IDLE -> FAULT on st_valid with st_size = 11 (or a misaligned address when REQ-032 applies); mem_req never rises.
REQ-024 SHALL make the transition BUSY -> DONE when mem_ack is sampled high; mem_req drops in the same edge.
REQ-025 SHALL make the transition BUSY -> FAULT when TIMEOUT_CYC cycles elapse in BUSY without mem_ack; mem_req drops.
REQ-026 SHALL give priority to ack over timeout when mem_ack coincides with the expiry cycle.
REQ-027 SHALL return from DONE and FAULT to IDLE after one cycle, with st_done or st_fault high exactly for that cycle.
REQ-028 SHALL drive st_ready = (state == IDLE); st_valid outside IDLE is ignored.
REQ-029 SHALL hold mem_addr, mem_wdata and mem_be stable while mem_req is high; the minimum accept-to-done latency is 3 cycles (ack on first mem_req cycle).
REQ-030 SHALL ignore mem_ack outside BUSY.

Reset
REQ-031 SHALL, while rst_n is low (immediately, asynchronously): set state to IDLE, clear the timeout counter, and drive mem_req, st_done, st_fault, mem_be, mem_addr and mem_wdata to 0; st_ready is 1 after reset; a store in flight is abandoned with no done or fault pulse.

Configuration
REQ-032 SHALL, with STORE_MISALIGN_TRAP_EN defined, take the IDLE -> FAULT path with no memory write for a half with addr[0] = 1 or a word with addr[1:0] != 00.
REQ-033 SHALL, with STORE_MISALIGN_TRAP_EN undefined, force misaligned addresses to natural alignment (low bits cleared) and perform the store normally.

Structure
REQ-034 SHALL place the st_size encodings, the FSM state enum and the lane-map constants in the shared package store_pkg.
REQ-035 SHALL place narrowing, replication and byte-enable generation in the combinational sub-module store_lane_mux; the FSM and timeout counter reside in store_narrow_unit.

Verification
REQ-036 SHALL cover: byte store, addr 0x1003, data 0x000000AB, ack after 2 cycles -> mem_addr 0x1000, be 0001, wdata 0xABABABAB, st_done one cycle after ack.
REQ-037 SHALL cover: half store, addr 0x2002, data 0x1234CDEF -> mem_addr 0x2000, be 0011, wdata 0xCDEFCDEF.
REQ-038 SHALL cover: word store, addr 0x3001 -> with the macro: st_fault pulse and no mem_req; without: mem_addr 0x3000, be 1111.
REQ-039 SHALL cover: TIMEOUT_CYC = 4 with no ack -> mem_req high 4 cycles then low, st_fault pulse; ack on cycle 4 -> st_done instead.
REQ-040 SHALL cover: st_size 11 -> st_fault pulse the next cycle, mem_req stays 0.
REQ-041 SHALL cover: rst_n low mid-BUSY -> mem_req 0 without a clock edge, st_ready 1 after release, no done or fault pulse.
